// File: rtl/thunder_pkg.sv
// Shared constants, field offsets and state encoding for the 8F-AB timing-packet
// epoch converter.
package thunder_pkg;

    localparam int unsigned c_OFS_SUBCODE = 0;
    localparam int unsigned c_OFS_TOW     = 1;
    localparam int unsigned c_OFS_WEEK    = 5;
    localparam int unsigned c_OFS_UTC_OFS = 7;
    localparam int unsigned c_OFS_FLAG    = 9;
    localparam int unsigned c_OFS_SEC     = 10;
    localparam int unsigned c_OFS_MIN     = 11;
    localparam int unsigned c_OFS_HOUR    = 12;
    localparam int unsigned c_OFS_DAY     = 13;
    localparam int unsigned c_OFS_MONTH   = 14;
    localparam int unsigned c_OFS_YEAR_HI = 15;
    localparam int unsigned c_OFS_YEAR_LO = 16;

    localparam logic [7:0]  c_TIM_SUBCODE = 8'hAB;
    localparam logic [15:0] c_BASE_YEAR   = 16'd2000;
    localparam logic [15:0] c_BASE_DAYS   = 16'd10957;
    localparam logic [15:0] c_MAX_YEAR    = 16'd2099;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_YEARS,
        ST_MONTHS,
        ST_SUM,
        ST_DONE
    } state_t;

    // Exact inside 2000..2099 where the century exception never applies.
    function automatic logic f_is_leap(input logic [1:0] year_lsbs);
        return (year_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/thunder_utc_epoch_dim.sv
// Days in a calendar month given the leap-year flag; shared by range checking
// and the month accumulation walk.
module days_in_month
    import thunder_pkg::*;
(
    input  logic [3:0] i_month,
    input  logic       i_leap,
    output logic [4:0] o_days
);

    always_comb begin
        o_days = 5'd31;
        case (i_month)
            4'd2:                      o_days = i_leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   o_days = 5'd30;
            default:                   o_days = 5'd31;
        endcase
    end

endmodule

// File: rtl/thunder_utc_epoch.sv
// Validates an 8F-AB timing packet and iteratively converts its UTC calendar
// fields to a 32-bit Unix epoch seconds count.
module thunder_utc_epoch
    import thunder_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_thunder_packet_dv,
    input  logic [135:0] i_thunder_data,
    output logic [31:0]  o_epoch_sec,
    output logic         o_epoch_dv,
    output logic         o_utc_flag,
    output logic         o_err,
    output logic         o_overrun,
    output logic         o_busy
);

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_subcode;
    logic [7:0]  r_sec;
    logic [7:0]  r_min;
    logic [7:0]  r_hr;
    logic [7:0]  r_day;
    logic [7:0]  r_mon;
    logic [15:0] r_year;
    logic        r_flag;

    logic [15:0] r_days;
    logic [15:0] r_yr;
    logic [3:0]  r_m;

    logic [31:0] r_epoch_sec;
    logic        r_epoch_dv;
    logic        r_utc_flag;
    logic        r_err;
    logic        r_overrun;

    logic [3:0]  w_dim_month;
    logic [4:0]  w_dim;
    logic        w_reject;
    logic [15:0] w_day_idx;
    logic [31:0] w_epoch;
    logic        w_unused_fields;

    assign w_unused_fields = ^{i_thunder_data[8*c_OFS_TOW +: 64],
                               i_thunder_data[8*c_OFS_FLAG+1 +: 7]};

    assign w_dim_month = (r_state == ST_MONTHS) ? r_m : r_mon[3:0];

    days_in_month u_dim (
        .i_month (w_dim_month),
        .i_leap  (f_is_leap(r_year[1:0])),
        .o_days  (w_dim)
    );

    always_comb begin
        w_reject = 1'b0;
        if (r_subcode != c_TIM_SUBCODE)
            w_reject = 1'b1;
        if (r_sec > 8'd60 || r_min > 8'd59 || r_hr > 8'd23)
            w_reject = 1'b1;
        if (r_mon == '0 || r_mon > 8'd12)
            w_reject = 1'b1;
        if (r_year < c_BASE_YEAR || r_year > c_MAX_YEAR)
            w_reject = 1'b1;
        if (r_day == '0 || r_day > {3'b000, w_dim})
            w_reject = 1'b1;
    end

    assign w_day_idx = r_days + {8'b0, r_day} - 16'd1;
    assign w_epoch   = {16'b0, w_day_idx} * 32'd86400
                     + {24'b0, r_hr}      * 32'd3600
                     + {24'b0, r_min}     * 32'd60
                     + {24'b0, r_sec};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_thunder_packet_dv) w_state_next = ST_CHECK;
            ST_CHECK:  w_state_next = w_reject ? ST_IDLE : ST_YEARS;
            ST_YEARS:  if (r_yr == r_year) w_state_next = ST_MONTHS;
            ST_MONTHS: if ({4'b0000, r_m} == r_mon) w_state_next = ST_SUM;
            ST_SUM:    w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_subcode   <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= '0;
            r_day       <= '0;
            r_mon       <= '0;
            r_year      <= '0;
            r_flag      <= 1'b0;
            r_days      <= '0;
            r_yr        <= '0;
            r_m         <= '0;
            r_epoch_sec <= '0;
            r_epoch_dv  <= 1'b0;
            r_utc_flag  <= 1'b0;
            r_err       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_epoch_dv <= 1'b0;
            r_err      <= 1'b0;
            r_overrun  <= i_thunder_packet_dv && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_thunder_packet_dv) begin
                        r_subcode <= i_thunder_data[8*c_OFS_SUBCODE +: 8];
                        r_sec     <= i_thunder_data[8*c_OFS_SEC +: 8];
                        r_min     <= i_thunder_data[8*c_OFS_MIN +: 8];
                        r_hr      <= i_thunder_data[8*c_OFS_HOUR +: 8];
                        r_day     <= i_thunder_data[8*c_OFS_DAY +: 8];
                        r_mon     <= i_thunder_data[8*c_OFS_MONTH +: 8];
                        r_year    <= {i_thunder_data[8*c_OFS_YEAR_HI +: 8],
                                      i_thunder_data[8*c_OFS_YEAR_LO +: 8]};
                        r_flag    <= i_thunder_data[8*c_OFS_FLAG];
                    end
                end
                ST_CHECK: begin
                    if (w_reject) begin
                        r_err <= 1'b1;
                    end else begin
                        r_days <= c_BASE_DAYS;
                        r_yr   <= c_BASE_YEAR;
                    end
                end
                ST_YEARS: begin
                    if (r_yr == r_year) begin
                        r_m <= 4'd1;
                    end else begin
                        r_days <= r_days + 16'd365 + {15'b0, f_is_leap(r_yr[1:0])};
                        r_yr   <= r_yr + 16'd1;
                    end
                end
                ST_MONTHS: begin
                    if ({4'b0000, r_m} != r_mon) begin
                        r_days <= r_days + {11'b0, w_dim};
                        r_m    <= r_m + 4'd1;
                    end
                end
                // Result registers load on the SUM->DONE edge so they are
                // visible, together with the strobe, during DONE.
                ST_SUM: begin
                    r_epoch_sec <= w_epoch;
                    r_utc_flag  <= r_flag;
                    r_epoch_dv  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_epoch_sec = r_epoch_sec;
    assign o_epoch_dv  = r_epoch_dv;
    assign o_utc_flag  = r_utc_flag;
    assign o_err       = r_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
